// File: rtl/verdict_collector_if.sv
// Record stream from the verdict collector to the host / trace consumer.
// The producer holds m_valid and m_data stable until m_ready accepts the record.
interface verdict_collector_if #(
   parameter int W = 227
);
   logic         m_valid;
   logic         m_ready;
   logic [W-1:0] m_data;

   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/verdict_collector.sv
// Verdict collector: captures every enabled cycle in which any of the monitor
// streams d/e/f is active, tags it with a cycle timestamp and queues it in a
// show-ahead FIFO drained over a valid/ready stream.
// Record layout: {ts, mask={f,e,d}, f, e, d}. Inactive value fields read as 0.
// A capture that finds the FIFO full without a pop in the same cycle is
// dropped and counted (sticky overflow flag, saturating counter).
module verdict_collector #(
   parameter int DATA_W = 64,
   parameter int TS_W   = 32,
   parameter int DEPTH  = 8,
   parameter int DROP_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [DATA_W-1:0]          output_d,
   input  logic                       output_d_aktv,
   input  logic [DATA_W-1:0]          output_e,
   input  logic                       output_e_aktv,
   input  logic [DATA_W-1:0]          output_f,
   input  logic                       output_f_aktv,
   verdict_collector_if.master        m_if,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic                       overflow,
   output logic [DROP_W-1:0]          drop_count
);
   localparam int AW    = $clog2(DEPTH);
   localparam int FW    = AW + 1;
   localparam int REC_W = TS_W + 3 + 3 * DATA_W;

   logic [REC_W-1:0]  mem [DEPTH];

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [FW-1:0]     fill_q, fill_d;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic              valid_q, valid_d;
   logic [REC_W-1:0]  data_q, data_d;
   logic              ovf_q, ovf_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic [2:0]        mask;
   logic [REC_W-1:0]  rec;
   logic              capture;
   logic              pop;
   logic              push;
   logic              drop;
   logic              full;

   // Next-state: capture/pop decisions, pointers, fill, timestamp, drop
   // accounting and the registered head-of-queue output.
   always_comb begin
      mask     = {output_f_aktv, output_e_aktv, output_d_aktv};
      rec      = {ts_q, mask,
                  output_f_aktv ? output_f : {DATA_W{1'b0}},
                  output_e_aktv ? output_e : {DATA_W{1'b0}},
                  output_d_aktv ? output_d : {DATA_W{1'b0}}};
      capture  = en & (|mask);
      pop      = valid_q & m_if.m_ready;
      full     = (fill_q == FW'(DEPTH));
      // A full FIFO still accepts a capture when the head leaves this cycle.
      push     = capture & (~full | pop);
      drop     = capture & full & ~pop;

      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      fill_d   = fill_q + FW'(push) - FW'(pop);
      ts_d     = en ? ts_q + TS_W'(1) : ts_q;
      ovf_d    = ovf_q | drop;
      drop_d   = drop_q;
      if (drop && (drop_q != {DROP_W{1'b1}})) begin
         drop_d = drop_q + DROP_W'(1);
      end

      // The output register is loaded with whatever will be at the head after
      // this edge. When the incoming record lands exactly at the new head slot
      // (FIFO empty, or one entry being replaced), forward it directly since
      // the array write has not happened yet.
      valid_d  = (fill_d != '0);
      data_d   = '0;
      if (valid_d) begin
         if (push && (wr_ptr_q == rd_ptr_d)) begin
            data_d = rec;
         end else begin
            data_d = mem[rd_ptr_d];
         end
      end
   end

   // Record storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr_q] <= rec;
      end
   end

   // State registers; reset empties the queue and clears all accounting.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         ts_q     <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         ts_q     <= ts_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   assign m_if.m_valid = valid_q;
   assign m_if.m_data  = data_q;
   assign fill_level   = fill_q;
   assign overflow     = ovf_q;
   assign drop_count   = drop_q;
endmodule

// File: tb/tb_verdict_collector.sv
// Bench for verdict_collector: a default-parameter instance plus a TS_W=4
// instance driven by identical stimulus. A reference queue holds every record
// expected to be in the FIFO; the head is compared whenever the DUT shows it.
module tb_verdict_collector;
   localparam int DW     = 64;
   localparam int PAY_W  = 3 + 3 * DW;
   localparam int REC_W  = 32 + PAY_W;
   localparam int REC4_W = 4 + PAY_W;

   logic          clk = 1'b0;
   logic          rst, en, da, ea, fa, m_ready;
   logic [DW-1:0] in_d, in_e, in_f;
   logic [3:0]    fill_level, fill4;
   logic          overflow, ovf4;
   logic [15:0]   drop_count, drop4;

   verdict_collector_if #(.W(REC_W))  m_if ();
   verdict_collector_if #(.W(REC4_W)) m4_if ();
   assign m_if.m_ready  = m_ready;
   assign m4_if.m_ready = m_ready;

   verdict_collector dut (
      .clk(clk), .rst(rst), .en(en),
      .output_d(in_d), .output_d_aktv(da),
      .output_e(in_e), .output_e_aktv(ea),
      .output_f(in_f), .output_f_aktv(fa),
      .m_if(m_if), .fill_level(fill_level), .overflow(overflow), .drop_count(drop_count)
   );

   verdict_collector #(.TS_W(4)) dut4 (
      .clk(clk), .rst(rst), .en(en),
      .output_d(in_d), .output_d_aktv(da),
      .output_e(in_e), .output_e_aktv(ea),
      .output_f(in_f), .output_f_aktv(fa),
      .m_if(m4_if), .fill_level(fill4), .overflow(ovf4), .drop_count(drop4)
   );

   always #5 clk = ~clk;

   int              n_cmp = 0;
   int              n_bad = 0;
   logic [31:0]     ts_m;
   logic [REC_W-1:0] q[$];
   int              drops_m;
   bit              ovf_m;

   // Advance one clock; the reference model consumes the inputs applied now.
   task automatic tick();
      logic [REC_W-1:0] r;
      bit pop, cap, full;
      if (rst) begin
         q.delete();
         ts_m    = '0;
         drops_m = 0;
         ovf_m   = 1'b0;
      end else begin
         pop  = (q.size() > 0) && m_ready;
         cap  = en && (da || ea || fa);
         full = (q.size() == 8);
         r    = {ts_m, fa, ea, da, fa ? in_f : 64'd0, ea ? in_e : 64'd0, da ? in_d : 64'd0};
         if (pop) void'(q.pop_front());
         if (cap) begin
            if (!full || pop) q.push_back(r);
            else begin
               ovf_m = 1'b1;
               if (drops_m < 65535) drops_m++;
            end
         end
         if (en) ts_m = ts_m + 32'd1;
      end
      @(negedge clk);
   endtask

   task automatic clear_aktv();
      da = 1'b0; ea = 1'b0; fa = 1'b0;
      in_d = '0; in_e = '0; in_f = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (m_if.m_valid !== 1'b0 || m_if.m_data !== '0 || m4_if.m_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_out: got valid=%0b data=%h want valid=0 data=0", m_if.m_valid, m_if.m_data);
      end
      n_cmp++;
      if (fill_level !== 4'd0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_status: got fill=%0d ovf=%0b drops=%0d want 0/0/0", fill_level, overflow, drop_count);
      end
      rst = 1'b0;
      en  = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         n_cmp++;
         if (m_if.m_valid !== 1'b0 || fill_level !== 4'd0) begin
            n_bad++;
            $display("FAIL idle_empty: got valid=%0b fill=%0d want 0/0", m_if.m_valid, fill_level);
         end
      end
   endtask

   task automatic test_single();
      logic [REC_W-1:0] exp_c;
      exp_c = {32'd7, 3'b001, 64'd0, 64'd0, 64'd5};
      in_d = 64'd5; da = 1'b1; m_ready = 1'b1;
      tick();
      clear_aktv();
      n_cmp++;
      if (m_if.m_valid !== 1'b1 || m_if.m_data !== exp_c || fill_level !== 4'd1) begin
         n_bad++;
         $display("FAIL single_rec: got v=%0b fill=%0d %h want v=1 fill=1 %h", m_if.m_valid, fill_level, m_if.m_data, exp_c);
      end
      n_cmp++;
      if (q.size() == 0 || m_if.m_data !== q[0]) begin
         n_bad++;
         $display("FAIL single_sb: got %h scoreboard entries=%0d", m_if.m_data, q.size());
      end else $display("pop ts=%0d mask=%b d=%0d", q[0][226:195], q[0][194:192], q[0][63:0]);
      tick();
      n_cmp++;
      if (m_if.m_valid !== 1'b0 || fill_level !== 4'd0) begin
         n_bad++;
         $display("FAIL single_popped: got valid=%0b fill=%0d want 0/0", m_if.m_valid, fill_level);
      end
   endtask

   task automatic test_all_three();
      m_ready = 1'b0;
      in_d = 64'hFFFF_FFFF_FFFF_FFFD; in_e = 64'd4; in_f = 64'd9;
      da = 1'b1; ea = 1'b1; fa = 1'b1;
      tick();
      clear_aktv();
      n_cmp++;
      if (m_if.m_valid !== 1'b1 || m_if.m_data[194:192] !== 3'b111 ||
          m_if.m_data[63:0] !== 64'hFFFF_FFFF_FFFF_FFFD || m_if.m_data[191:128] !== 64'd9) begin
         n_bad++;
         $display("FAIL all3_fields: got v=%0b %h want mask=111 d=-3 f=9", m_if.m_valid, m_if.m_data);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (q.size() == 0 || m_if.m_valid !== 1'b1 || m_if.m_data !== q[0]) begin
            n_bad++;
            $display("FAIL all3_stall: got v=%0b %h want held record", m_if.m_valid, m_if.m_data);
         end
      end
      $display("pop ts=%0d mask=%b d=%0d", q[0][226:195], q[0][194:192], $signed(q[0][63:0]));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      n_cmp++;
      if (m_if.m_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL all3_popped: got valid=%0b want 0", m_if.m_valid);
      end
   endtask

   task automatic test_overflow();
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         da = 1'b1; in_d = 64'(100 + i);
         ea = i[0]; in_e = 64'(i * 3);
         tick();
      end
      clear_aktv();
      n_cmp++;
      if (fill_level !== 4'd8 || overflow !== 1'b1 || drop_count !== 16'd2) begin
         n_bad++;
         $display("FAIL ovf_status: got fill=%0d ovf=%0b drops=%0d want 8/1/2", fill_level, overflow, drop_count);
      end
      n_cmp++;
      if (q.size() == 0 || m_if.m_data[63:0] !== 64'd100 || m_if.m_data !== q[0]) begin
         n_bad++;
         $display("FAIL ovf_head: got %h want first record d=100", m_if.m_data);
      end
   endtask

   task automatic test_full_pop();
      int n;
      da = 1'b1; in_d = 64'd200; m_ready = 1'b1;
      tick();
      clear_aktv();
      m_ready = 1'b0;
      n_cmp++;
      if (fill_level !== 4'd8 || drop_count !== 16'd2 || m_if.m_data[63:0] !== 64'd101) begin
         n_bad++;
         $display("FAIL fullpop: got fill=%0d drops=%0d d=%0d want 8/2/101", fill_level, drop_count, m_if.m_data[63:0]);
      end
      m_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 20 && q.size() > 0; c++) begin
         n_cmp++;
         if (m_if.m_valid !== 1'b1 || m_if.m_data !== q[0]) begin
            n_bad++;
            $display("FAIL drain_rec: got v=%0b %h want v=1 %h", m_if.m_valid, m_if.m_data, q[0]);
         end else $display("pop ts=%0d mask=%b d=%0d", q[0][226:195], q[0][194:192], q[0][63:0]);
         n++;
         tick();
      end
      m_ready = 1'b0;
      n_cmp++;
      if (n != 8 || m_if.m_valid !== 1'b0 || overflow !== 1'b1 || drop_count !== 16'd2) begin
         n_bad++;
         $display("FAIL drain_end: got n=%0d v=%0b ovf=%0b drops=%0d want 8/0/1/2", n, m_if.m_valid, overflow, drop_count);
      end
   endtask

   task automatic test_back_to_back();
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         da = 1'b1; in_d = 64'(300 + i);
         tick();
      end
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         fa = 1'b1; in_f = 64'(310 + i); da = 1'b0;
         n_cmp++;
         if (q.size() == 0 || fill_level !== 4'd3 || m_if.m_data !== q[0]) begin
            n_bad++;
            $display("FAIL b2b_rec: got fill=%0d %h want fill=3 head", fill_level, m_if.m_data);
         end else $display("pop ts=%0d mask=%b d=%0d f=%0d", q[0][226:195], q[0][194:192], q[0][63:0], q[0][191:128]);
         tick();
      end
      clear_aktv();
      for (int c = 0; c < 10 && q.size() > 0; c++) begin
         n_cmp++;
         if (m_if.m_valid !== 1'b1 || m_if.m_data !== q[0]) begin
            n_bad++;
            $display("FAIL b2b_drain: got v=%0b %h want %h", m_if.m_valid, m_if.m_data, q[0]);
         end else $display("pop ts=%0d mask=%b f=%0d", q[0][226:195], q[0][194:192], q[0][191:128]);
         tick();
      end
      m_ready = 1'b0;
      n_cmp++;
      if (m_if.m_valid !== 1'b0 || fill_level !== 4'd0) begin
         n_bad++;
         $display("FAIL b2b_empty: got v=%0b fill=%0d want 0/0", m_if.m_valid, fill_level);
      end
   endtask

   task automatic test_ts_wrap();
      logic [3:0] ta4;
      logic [3:0] exp4 [3];
      m_ready = 1'b0;
      ta4 = ts_m[3:0];
      exp4[0] = ta4; exp4[1] = ta4; exp4[2] = ta4 + 4'd1;
      da = 1'b1; in_d = 64'd1;
      tick();
      clear_aktv();
      for (int i = 0; i < 15; i++) tick();
      da = 1'b1; in_d = 64'd2;
      tick();
      en = 1'b0; in_d = 64'd3;
      tick();
      en = 1'b1; in_d = 64'd4;
      n_cmp++;
      if (fill_level !== 4'd2 || fill4 !== 4'd2) begin
         n_bad++;
         $display("FAIL en_low_ignored: got fill=%0d fill4=%0d want 2/2", fill_level, fill4);
      end
      tick();
      clear_aktv();
      m_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (q.size() == 0 || m4_if.m_valid !== 1'b1 || m4_if.m_data[198:195] !== exp4[k] ||
             m4_if.m_data[194:0] !== q[0][194:0] || m_if.m_data !== q[0]) begin
            n_bad++;
            $display("FAIL ts4_rec%0d: got ts4=%0d %h want ts4=%0d", k, m4_if.m_data[198:195], m4_if.m_data, exp4[k]);
         end else $display("pop ts4=%0d mask=%b d=%0d", m4_if.m_data[198:195], q[0][194:192], q[0][63:0]);
         if (k < 2) tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (m_if.m_valid !== 1'b0 || m4_if.m_valid !== 1'b0 || fill_level !== 4'd0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
         n_bad++;
         $display("FAIL rst_mid_drain: got v=%0b v4=%0b fill=%0d ovf=%0b drops=%0d want all 0",
                  m_if.m_valid, m4_if.m_valid, fill_level, overflow, drop_count);
      end
      tick();
      n_cmp++;
      if (m_if.m_valid !== 1'b0 || fill4 !== 4'd0) begin
         n_bad++;
         $display("FAIL rst_discard: got v=%0b fill4=%0d want 0/0", m_if.m_valid, fill4);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; m_ready = 1'b0;
      clear_aktv();
      ts_m = '0; drops_m = 0; ovf_m = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_all_three();
      test_overflow();
      test_full_pop();
      test_back_to_back();
      test_ts_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end
endmodule
